// File: rtl/io_hub_pkg.sv
`default_nettype none
// ============================================================================
// io_hub_pkg : shared state encoding and local register map for io_hub.
// Rev 1.0
// ============================================================================
package io_hub_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } hub_state_e;

  // Local register map: divider k lives at DIV_BASE + k, status right after the dividers.
  localparam int DIV_BASE = 0;

  function automatic int status_offset(input int num_ch);
    return DIV_BASE + num_ch;
  endfunction

endpackage
`default_nettype wire

// File: rtl/io_hub_if.sv
`default_nettype none
// ============================================================================
// io_hub_if : CPU request/response and peripheral channel signals of io_hub.
// Rev 1.0
// ============================================================================
interface io_hub_if #(
  parameter int NUM_CH = 2,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16
);
  localparam int SEL_W = $clog2(NUM_CH + 1);
  localparam int OFF_W = ADDR_W - SEL_W;

  logic                     req_valid;
  logic                     req_ready;
  logic                     req_we;
  logic [ADDR_W-1:0]        req_addr;
  logic [DATA_W-1:0]        req_wdata;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [DATA_W-1:0]        rsp_rdata;
  logic                     rsp_err;
  logic [NUM_CH-1:0]        p_sel;
  logic                     p_we;
  logic [OFF_W-1:0]         p_addr;
  logic [DATA_W-1:0]        p_wdata;
  logic [NUM_CH-1:0]        p_ready;
  logic [NUM_CH*DATA_W-1:0] p_rdata;
  logic [NUM_CH-1:0]        ce;

  // CPU and peripheral side, driving requests and completions into the hub.
  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready, p_ready, p_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, p_sel, p_we, p_addr, p_wdata, ce
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready, p_ready, p_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, p_sel, p_we, p_addr, p_wdata, ce
  );

endinterface
`default_nettype wire

// File: rtl/io_hub_ce_div.sv
`default_nettype none
// ============================================================================
// io_hub_ce_div : programmable clock-enable, one pulse every div+1 cycles.
// Rev 1.0
// ============================================================================
module io_hub_ce_div #(
  parameter int DIV_W   = 16,
  parameter int DIV_RST = 15
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             load,
  input  logic [DIV_W-1:0] load_val,
  output logic             ce,
  output logic [DIV_W-1:0] div
);
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;

  always_comb begin
    ce    = (cnt_q == div_q);
    div_d = div_q;
    cnt_d = ce ? '0 : cnt_q + 1'b1;
    // A new divisor restarts the period from a cleared counter.
    if (load) begin
      div_d = load_val;
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      div_q <= DIV_W'(DIV_RST);
      cnt_q <= '0;
    end else begin
      div_q <= div_d;
      cnt_q <= cnt_d;
    end
  end

  assign div = div_q;

endmodule
`default_nettype wire

// File: rtl/io_hub.sv
`default_nettype none
// ============================================================================
// io_hub : decodes CPU requests onto NUM_CH valid/ready peripheral channels,
//          with access timeout, sticky status and per-channel clock enables.
// Rev 1.0
// ============================================================================
module io_hub
  import io_hub_pkg::*;
#(
  parameter int NUM_CH  = 2,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 16,
  parameter int DIV_W   = 16,
  parameter int DIV_RST = 15,
  parameter int TIMEOUT = 255
) (
  input  logic    clk_in,
  input  logic    rst,
  io_hub_if.slave bus
);
  localparam int SEL_W      = $clog2(NUM_CH + 1);
  localparam int OFF_W      = ADDR_W - SEL_W;
  localparam int TCNT_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int STATUS_OFF = status_offset(NUM_CH);

  hub_state_e          state_q, state_d;
  logic                req_ready_q, req_ready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic [NUM_CH-1:0]   p_sel_q, p_sel_d;
  logic                p_we_q, p_we_d;
  logic [OFF_W-1:0]    p_addr_q, p_addr_d;
  logic [DATA_W-1:0]   p_wdata_q, p_wdata_d;
  logic [TCNT_W-1:0]   tcnt_q, tcnt_d;
  logic [NUM_CH-1:0]   tflag_q, tflag_d;

  logic [SEL_W-1:0]    req_sel;
  logic [OFF_W-1:0]    req_off;
  logic [DATA_W-1:0]   local_rdata;
  logic [DATA_W-1:0]   sel_rdata;
  logic                sel_ready;
  logic [NUM_CH-1:0]   div_load;
  logic [NUM_CH-1:0]   ce_vec;
  logic [DIV_W-1:0]    div_val [NUM_CH];

  assign req_sel = bus.req_addr[ADDR_W-1 -: SEL_W];
  assign req_off = bus.req_addr[OFF_W-1:0];

  always_comb begin
    local_rdata = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (req_off == OFF_W'(DIV_BASE + k)) local_rdata = DATA_W'(div_val[k]);
    end
    if (req_off == OFF_W'(STATUS_OFF)) local_rdata = DATA_W'(tflag_q);
  end

  // p_sel_q is one-hot, so masking p_ready with it ignores idle channels.
  assign sel_ready = |(bus.p_ready & p_sel_q);

  always_comb begin
    sel_rdata = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (p_sel_q[k]) sel_rdata = bus.p_rdata[k*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    state_d     = state_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    p_sel_d     = p_sel_q;
    p_we_d      = p_we_q;
    p_addr_d    = p_addr_q;
    p_wdata_d   = p_wdata_q;
    tcnt_d      = tcnt_q;
    tflag_d     = tflag_q;
    div_load    = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          req_ready_d = 1'b0;
          p_we_d      = bus.req_we;
          p_addr_d    = req_off;
          p_wdata_d   = bus.req_wdata;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = '0;
          tcnt_d      = '0;
          if (req_sel < SEL_W'(NUM_CH)) begin
            state_d = ST_ACCESS;
            for (int k = 0; k < NUM_CH; k++) p_sel_d[k] = (req_sel == SEL_W'(k));
          end else if (req_sel == SEL_W'(NUM_CH)) begin
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            if (bus.req_we) begin
              for (int k = 0; k < NUM_CH; k++) div_load[k] = (req_off == OFF_W'(DIV_BASE + k));
              if (req_off == OFF_W'(STATUS_OFF)) tflag_d = tflag_q & ~NUM_CH'(bus.req_wdata);
            end else begin
              rsp_rdata_d = local_rdata;
            end
          end else begin
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end
        end
      end

      ST_ACCESS: begin
        if (sel_ready) begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = p_we_q ? '0 : sel_rdata;
          p_sel_d     = '0;
        end else if (tcnt_q == TCNT_W'(TIMEOUT - 1)) begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
          tflag_d     = tflag_q | p_sel_q;
          p_sel_d     = '0;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end

      ST_RESP: begin
        if (bus.rsp_ready) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
        end
      end

      default: begin
        state_d     = ST_IDLE;
        req_ready_d = 1'b1;
        rsp_valid_d = 1'b0;
        p_sel_d     = '0;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      p_sel_q     <= '0;
      p_we_q      <= 1'b0;
      p_addr_q    <= '0;
      p_wdata_q   <= '0;
      tcnt_q      <= '0;
      tflag_q     <= '0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      p_sel_q     <= p_sel_d;
      p_we_q      <= p_we_d;
      p_addr_q    <= p_addr_d;
      p_wdata_q   <= p_wdata_d;
      tcnt_q      <= tcnt_d;
      tflag_q     <= tflag_d;
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ce
    io_hub_ce_div #(
      .DIV_W   (DIV_W),
      .DIV_RST (DIV_RST)
    ) u_ce_div (
      .clk_in   (clk_in),
      .rst      (rst),
      .load     (div_load[k]),
      .load_val (DIV_W'(bus.req_wdata)),
      .ce       (ce_vec[k]),
      .div      (div_val[k])
    );
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.p_sel     = p_sel_q;
  assign bus.p_we      = p_we_q;
  assign bus.p_addr    = p_addr_q;
  assign bus.p_wdata   = p_wdata_q;
  assign bus.ce        = ce_vec;

endmodule
`default_nettype wire

// File: tb/tb_io_hub.sv
`default_nettype none
// ============================================================================
// tb_io_hub : randomized self-checking bench for io_hub against a cycle-count
//             reference model (NUM_CH=2, TIMEOUT=8).
// Rev 1.0
// ============================================================================
module tb_io_hub;
  localparam int NUM_CH  = 2;
  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 16;
  localparam int TIMEOUT = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  // Reference model state
  int                mdiv [NUM_CH];
  int                t0   [NUM_CH];
  logic [NUM_CH-1:0] mflag;

  // Results of the last access
  logic [31:0]       res_rdata, res_pwdata;
  logic              res_err, res_pwe, res_to, res_stable, res_done;
  logic [NUM_CH-1:0] res_psel;
  logic [13:0]       res_paddr;
  int                res_acc, res_wait, res_acc_cyc;

  io_hub_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  io_hub #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .ADDR_W(ADDR_W),
    .DIV_W(16), .DIV_RST(15), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk_in (clk),
    .rst    (rst_n),
    .bus    (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Pulse k occurs when (cycles since counter cleared) mod (div+1) == div.
  function automatic logic [NUM_CH-1:0] exp_ce();
    logic [NUM_CH-1:0] e;
    for (int k = 0; k < NUM_CH; k++) e[k] = (((cyc - t0[k]) % (mdiv[k] + 1)) == mdiv[k]);
    return e;
  endfunction

  task automatic access(input logic we, input logic [15:0] addr, input logic [31:0] wd,
                        input int lat, input logic [31:0] prd, input int hold, input logic noise);
    logic [1:0]        sel;
    logic [NUM_CH-1:0] mask, pr;
    int                n;
    sel  = addr[15:14];
    mask = (sel < 2'(NUM_CH)) ? NUM_CH'(1 << sel) : '0;
    res_psel = '0; res_paddr = '0; res_pwe = 1'b0; res_pwdata = '0;
    res_acc = 0; res_to = 1'b0; res_stable = 1'b1; res_done = 1'b0;
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_addr = addr; bus.req_wdata = wd;
    step();
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    res_acc_cyc = cyc;
    n = 0;
    while (bus.rsp_valid !== 1'b1 && n < 200) begin
      pr = noise ? (NUM_CH'($urandom) & ~mask) : '0;
      if (bus.p_sel != '0) begin
        res_psel   = res_psel | bus.p_sel;
        res_paddr  = bus.p_addr;
        res_pwe    = bus.p_we;
        res_pwdata = bus.p_wdata;
        if (res_acc == lat) pr = pr | mask;
        res_acc++;
      end
      bus.p_ready = pr;
      for (int k = 0; k < NUM_CH; k++)
        bus.p_rdata[k*DATA_W +: DATA_W] = (k == int'(sel)) ? prd : $urandom();
      step();
      n++;
    end
    bus.p_ready = '0;
    res_wait = n;
    if (bus.rsp_valid !== 1'b1) begin
      res_to = 1'b1;
      return;
    end
    res_rdata = bus.rsp_rdata;
    res_err   = bus.rsp_err;
    if (bus.req_ready !== 1'b0 || bus.p_sel !== '0) res_stable = 1'b0;
    for (int h = 0; h < hold; h++) begin
      step();
      if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== res_rdata ||
          bus.rsp_err !== res_err || bus.req_ready !== 1'b0) res_stable = 1'b0;
    end
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
    res_done = (bus.rsp_valid === 1'b0 && bus.req_ready === 1'b1);
  endtask

  task automatic model_reset();
    cyc = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      mdiv[k] = 15;
      t0[k]   = 0;
    end
    mflag = '0;
  endtask

  task automatic test_reset();
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    bus.rsp_ready = 1'b0; bus.p_ready = '0; bus.p_rdata = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.p_sel, bus.p_we, bus.ce} !== 8'b1000_0000 ||
        bus.rsp_rdata !== '0 || bus.p_addr !== '0 || bus.p_wdata !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got rdy=%b vld=%b err=%b sel=%b we=%b ce=%b rd=%h a=%h wd=%h expected 1 0 0 00 0 00 0 0 0",
               bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.p_sel, bus.p_we, bus.ce,
               bus.rsp_rdata, bus.p_addr, bus.p_wdata);
    end
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 36; i++) begin
      n_checks++;
      if (bus.ce !== exp_ce()) begin
        n_fail++;
        $display("FAIL reset_ce cyc=%0d: got %b expected %b", cyc, bus.ce, exp_ce());
      end
      step();
    end
    // Abort an access in flight.
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = 16'h0010;
    step();
    bus.req_valid = 1'b0;
    step();
    step();
    n_checks++;
    if (bus.p_sel !== 2'b01) begin
      n_fail++;
      $display("FAIL reset_psel_before: got %b expected 01", bus.p_sel);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.p_sel !== 2'b00 || bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_abort: got sel=%b vld=%b rdy=%b expected 00 0 1",
               bus.p_sel, bus.rsp_valid, bus.req_ready);
    end
    step();
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 34; i++) begin
      n_checks++;
      if (bus.ce !== exp_ce() || bus.rsp_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_ce_after cyc=%0d: got ce=%b vld=%b expected ce=%b vld=0",
                 cyc, bus.ce, bus.rsp_valid, exp_ce());
      end
      step();
    end
  endtask

  task automatic test_read_ch1();
    access(1'b0, 16'h4003, 32'h0, 3, 32'hA5A5_0001, 0, 1'b1);
    n_checks++;
    if (res_to !== 1'b0 || res_rdata !== 32'hA5A5_0001 || res_err !== 1'b0 || res_done !== 1'b1) begin
      n_fail++;
      $display("FAIL read_ch1: got to=%b rd=%h err=%b done=%b expected 0 a5a50001 0 1",
               res_to, res_rdata, res_err, res_done);
    end
    n_checks++;
    if (res_paddr !== 14'h0003 || res_psel !== 2'b10 || res_pwe !== 1'b0 || res_acc !== 4) begin
      n_fail++;
      $display("FAIL read_ch1_bus: got addr=%h sel=%b we=%b acc=%0d expected 0003 10 0 4",
               res_paddr, res_psel, res_pwe, res_acc);
    end
  endtask

  task automatic test_write_ch0();
    logic [31:0] wd;
    wd = $urandom();
    access(1'b1, 16'h0025, wd, 2, 32'hDEAD_BEEF, 0, 1'b1);
    n_checks++;
    if (res_to !== 1'b0 || res_rdata !== 32'h0 || res_err !== 1'b0 || res_pwdata !== wd ||
        res_pwe !== 1'b1 || res_paddr !== 14'h0025 || res_acc !== 3) begin
      n_fail++;
      $display("FAIL write_ch0: got to=%b rd=%h err=%b wd=%h we=%b a=%h acc=%0d expected 0 0 0 %h 1 0025 3",
               res_to, res_rdata, res_err, res_pwdata, res_pwe, res_paddr, res_acc, wd);
    end
  endtask

  task automatic test_timeout();
    access(1'b0, 16'h0007, 32'h0, 1000, 32'h1234_5678, 0, 1'b0);
    n_checks++;
    if (res_to !== 1'b0 || res_err !== 1'b1 || res_rdata !== 32'h0 || res_acc !== TIMEOUT) begin
      n_fail++;
      $display("FAIL timeout: got to=%b err=%b rd=%h acc=%0d expected 0 1 0 %0d",
               res_to, res_err, res_rdata, res_acc, TIMEOUT);
    end
    mflag[0] = 1'b1;
    access(1'b0, 16'h8002, 32'h0, 0, 32'h0, 0, 1'b0);
    n_checks++;
    if (res_rdata !== 32'h1 || res_err !== 1'b0) begin
      n_fail++;
      $display("FAIL status_set: got rd=%h err=%b expected 1 0", res_rdata, res_err);
    end
    access(1'b1, 16'h8002, 32'h1, 0, 32'h0, 0, 1'b0);
    mflag[0] = 1'b0;
    access(1'b0, 16'h8002, 32'h0, 0, 32'h0, 0, 1'b0);
    n_checks++;
    if (res_rdata !== 32'h0 || res_err !== 1'b0) begin
      n_fail++;
      $display("FAIL status_clear: got rd=%h err=%b expected 0 0", res_rdata, res_err);
    end
  endtask

  task automatic test_bad_select();
    access(1'b0, 16'hC123, 32'h0, 0, 32'hFFFF_FFFF, 0, 1'b1);
    n_checks++;
    if (res_to !== 1'b0 || res_err !== 1'b1 || res_rdata !== 32'h0 || res_wait !== 0 || res_psel !== 2'b00) begin
      n_fail++;
      $display("FAIL bad_select: got to=%b err=%b rd=%h wait=%0d sel=%b expected 0 1 0 0 00",
               res_to, res_err, res_rdata, res_wait, res_psel);
    end
  endtask

  task automatic test_divider();
    access(1'b1, 16'h8000, 32'h0, 0, 32'h0, 0, 1'b0);
    mdiv[0] = 0;
    t0[0]   = res_acc_cyc;
    for (int i = 0; i < 12; i++) begin
      n_checks++;
      if (bus.ce[0] !== 1'b1 || bus.ce !== exp_ce()) begin
        n_fail++;
        $display("FAIL div0_ce cyc=%0d: got %b expected %b", cyc, bus.ce, exp_ce());
      end
      step();
    end
    access(1'b0, 16'h8000, 32'h0, 0, 32'h0, 0, 1'b0);
    n_checks++;
    if (res_rdata !== 32'h0 || res_err !== 1'b0) begin
      n_fail++;
      $display("FAIL div0_readback: got rd=%h err=%b expected 0 0", res_rdata, res_err);
    end
    access(1'b1, 16'h8000, 32'h3, 0, 32'h0, 0, 1'b0);
    mdiv[0] = 3;
    t0[0]   = res_acc_cyc;
    for (int i = 0; i < 24; i++) begin
      n_checks++;
      if (bus.ce !== exp_ce()) begin
        n_fail++;
        $display("FAIL div3_ce cyc=%0d: got %b expected %b", cyc, bus.ce, exp_ce());
      end
      step();
    end
    access(1'b0, 16'h8005, 32'h0, 0, 32'h0, 0, 1'b0);
    n_checks++;
    if (res_rdata !== 32'h0 || res_err !== 1'b0) begin
      n_fail++;
      $display("FAIL unmapped_read: got rd=%h err=%b expected 0 0", res_rdata, res_err);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] prd;
    prd = $urandom();
    access(1'b0, 16'h0100, 32'h0, 1, prd, 5, 1'b0);
    n_checks++;
    if (res_to !== 1'b0 || res_stable !== 1'b1 || res_done !== 1'b1 || res_rdata !== prd || res_err !== 1'b0) begin
      n_fail++;
      $display("FAIL backpressure: got to=%b stable=%b done=%b rd=%h err=%b expected 0 1 1 %h 0",
               res_to, res_stable, res_done, res_rdata, res_err, prd);
    end
  endtask

  task automatic test_back_to_back();
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = 16'hC000;
    step();
    n_checks++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b1 || bus.req_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_first: got vld=%b err=%b rdy=%b expected 1 1 0",
               bus.rsp_valid, bus.rsp_err, bus.req_ready);
    end
    bus.req_addr  = 16'h8001;
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
    n_checks++;
    if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_not_accepted: got vld=%b rdy=%b expected 0 1", bus.rsp_valid, bus.req_ready);
    end
    step();
    bus.req_valid = 1'b0;
    n_checks++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b0 || bus.rsp_rdata !== 32'(mdiv[1])) begin
      n_fail++;
      $display("FAIL b2b_second: got vld=%b err=%b rd=%h expected 1 0 %h",
               bus.rsp_valid, bus.rsp_err, bus.rsp_rdata, 32'(mdiv[1]));
    end
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_random();
    int                kind, lat, hold, r;
    logic              we;
    logic [1:0]        sel;
    logic [13:0]       off;
    logic [31:0]       wd, prd, exp_rd;
    logic              exp_err;
    logic [NUM_CH-1:0] exp_psel;
    for (int t = 0; t < 40; t++) begin
      kind = $urandom_range(0, 9);
      we   = 1'(($urandom() & 1));
      wd   = $urandom();
      prd  = $urandom();
      lat  = $urandom_range(0, 11);
      hold = $urandom_range(0, 3);
      off  = 14'($urandom());
      if (kind <= 5) begin
        sel = 2'($urandom_range(0, 1));
      end else if (kind <= 8) begin
        sel = 2'd2;
        r   = $urandom_range(0, 4);
        if (r <= 1) begin
          off = 14'(r);
          wd  = $urandom_range(0, 20);
        end else if (r == 2) begin
          off = 14'd2;
        end else begin
          off = 14'($urandom_range(3, 16383));
        end
      end else begin
        sel = 2'd3;
      end
      exp_err  = 1'b0;
      exp_rd   = '0;
      exp_psel = '0;
      if (sel == 2'd3) begin
        exp_err = 1'b1;
      end else if (sel == 2'd2) begin
        if (!we) begin
          if (off < 14'd2) exp_rd = 32'(mdiv[int'(off)]);
          else if (off == 14'd2) exp_rd = 32'(mflag);
        end
      end else begin
        exp_psel = NUM_CH'(1 << sel);
        if (lat <= TIMEOUT - 1) exp_rd = we ? 32'h0 : prd;
        else exp_err = 1'b1;
      end
      access(we, {sel, off}, wd, lat, prd, hold, 1'b1);
      n_checks++;
      if (res_to !== 1'b0 || res_err !== exp_err || res_rdata !== exp_rd ||
          res_psel !== exp_psel || res_done !== 1'b1 || res_stable !== 1'b1) begin
        n_fail++;
        $display("FAIL random[%0d] sel=%0d off=%h we=%b lat=%0d: got to=%b err=%b rd=%h psel=%b done=%b stable=%b expected 0 %b %h %b 1 1",
                 t, sel, off, we, lat, res_to, res_err, res_rdata, res_psel, res_done, res_stable,
                 exp_err, exp_rd, exp_psel);
      end
      if (sel == 2'd2 && we) begin
        if (off < 14'd2) begin
          mdiv[int'(off)] = int'(wd[15:0]);
          t0[int'(off)]   = res_acc_cyc;
        end else if (off == 14'd2) begin
          mflag = mflag & ~wd[NUM_CH-1:0];
        end
      end
      if (sel < 2'd2 && lat > TIMEOUT - 1) mflag[sel] = 1'b1;
    end
    access(1'b0, 16'h8002, 32'h0, 0, 32'h0, 0, 1'b0);
    n_checks++;
    if (res_rdata !== 32'(mflag)) begin
      n_fail++;
      $display("FAIL random_status: got %h expected %h", res_rdata, 32'(mflag));
    end
    for (int i = 0; i < 30; i++) begin
      n_checks++;
      if (bus.ce !== exp_ce()) begin
        n_fail++;
        $display("FAIL random_ce cyc=%0d: got %b expected %b", cyc, bus.ce, exp_ce());
      end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_read_ch1();
    test_write_ch0();
    test_timeout();
    test_bad_select();
    test_divider();
    test_backpressure();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
